posit_unit_rr_arbiter: RTL
==========================

// Module: posit_unit_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one posit arithmetic unit among N_REQ requesters
//  (DAG PE lanes). Grants are registered and held until the transaction ends.
//  Rotating-priority search over the request vector. Hold-length watchdog.
//  Sits between the PE request lanes and the posit unit's operand mux select.
// PARAMETERS
//  N_REQ     8   number of requesters (>=2, need not be a power of 2)
//  MAX_HOLD  16  max cycles a grant may be held before forced release (>=2)
// PORTS
//  clk        in   1                   clock, all state on rising edge
//  rst        in   1                   asynchronous, active-high reset
//  req        in   N_REQ               level request per requester
//  res_done   in   1                   1-cycle pulse: posit unit finished current op
//  gnt        out  N_REQ               one-hot grant, registered (all 0 when idle)
//  gnt_idx    out  $clog2(N_REQ)       index of granted requester, valid when gnt_vld
//  gnt_vld    out  1                   high while a grant is held (== |gnt)
//  timeout    out  1                   1-cycle pulse: grant force-released by watchdog
// BEHAVIOUR
//  Reset (async, rst=1): gnt=0, gnt_vld=0, gnt_idx=0, timeout=0, state=IDLE,
//   last_idx=N_REQ-1 (first search starts at index 0), hold_cnt=0.
//  States: IDLE, HOLD.
//  IDLE: if |req==0 stay IDLE, outputs 0. Else pick winner w = first i with
//   req[i]=1 scanning i = last_idx+1, last_idx+2, ... modulo N_REQ (wrap past
//   N_REQ-1 to 0; last_idx itself scanned last). Next edge: state=HOLD,
//   gnt=onehot(w), gnt_idx=w, gnt_vld=1, last_idx=w, hold_cnt=0.
//   Grant latency: 1 cycle from req sampled in IDLE to gnt high.
//  HOLD: hold_cnt increments each cycle (saturates, no wrap). Release when any of:
//   (a) res_done=1, (b) req[gnt_idx]=0, (c) hold_cnt==MAX_HOLD-1.
//   On release edge: state=IDLE, gnt=0, gnt_vld=0; gnt_idx keeps last value.
//   timeout=1 for exactly that one cycle only if (c) is true and (a),(b) false.
//  Simultaneous release causes: single release, timeout suppressed if (a)|(b).
//  Releases always insert one IDLE cycle (gnt=0) before the next grant;
//   no back-to-back grants. Requests changing in HOLD do not affect the grant.
//  Fairness: with all req held high, grants visit 0,1,..,N_REQ-1,0,... in order.
//  res_done while IDLE is ignored. Non-owner req drops ignored.
//  rst asserted mid-HOLD: outputs clear immediately (async); last_idx returns to
//   N_REQ-1, so post-reset arbitration restarts at index 0.
//  gnt_idx width: $clog2(N_REQ); indices >= N_REQ never produced.
//  Invariants: gnt is zero or one-hot; gnt_vld == |gnt; gnt[gnt_idx]==gnt_vld.
// TESTING
//  1 Reset: rst=1 with req=8'hFF -> gnt=0, gnt_vld=0, timeout=0 throughout.
//  2 Single req: req=8'h10 at cycle 0 -> gnt=8'h10, gnt_idx=4 at cycle 1;
//    res_done at cycle 3 -> gnt=0 at cycle 4; next grant no earlier than cycle 5.
//  3 Rotation: req=8'hFF held, res_done every HOLD cycle -> gnt_idx sequence
//    0,1,2,...,7,0 with one idle cycle between each grant.
//  4 Wrap/skip: last_idx=6, req=8'h05 -> grant idx 0, then idx 2, then idx 0.
//  5 Watchdog: MAX_HOLD=16, req=8'h01 held, no res_done -> gnt high 16 cycles,
//    timeout=1 on release cycle only; same with res_done on cycle 16 -> timeout=0.
//  6 Mid-op reset + odd N: N_REQ=5, grant idx 3, assert rst -> gnt=0 same cycle;
//    after release req=5'b11111 -> first grant idx 0; scan wraps 4->0, never idx>4.

Source files
------------

// File: rtl/posit_unit_rr_arbiter.sv
// Round-robin arbiter granting one shared posit unit to one of N_REQ PE lanes.
// Grants are registered, held until done/drop/watchdog, and always followed by one idle cycle.
module posit_unit_rr_arbiter #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic                     res_done,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     gnt_vld,
    output logic                     timeout
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_HOLD);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state_reg, state_next;
    logic [N_REQ-1:0]  gnt_reg, gnt_next;
    logic [IW-1:0]     gnt_idx_reg, gnt_idx_next;
    logic [IW-1:0]     last_idx_reg, last_idx_next;
    logic [CW-1:0]     hold_cnt_reg, hold_cnt_next;
    logic              timeout_reg, timeout_next;

    // Candidate gi is the requester at distance gi+1 after the previous winner.
    logic [IW-1:0]     cand_idx [N_REQ];
    logic [N_REQ-1:0]  cand_hit;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [IW:0] sum;
            logic [IW:0] wrapped;
            assign sum          = {1'b0, last_idx_reg} + (IW+1)'(gi + 1);
            assign wrapped      = (sum >= (IW+1)'(N_REQ)) ? (sum - (IW+1)'(N_REQ)) : sum;
            assign cand_idx[gi] = wrapped[IW-1:0];
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    logic          win_found;
    logic [IW-1:0] win_idx;

    // Descending scan so the nearest candidate overwrites farther ones.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

    logic rel_done, rel_drop, rel_wd;

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        gnt_idx_next  = gnt_idx_reg;
        last_idx_next = last_idx_reg;
        hold_cnt_next = hold_cnt_reg;
        timeout_next  = 1'b0;
        rel_done      = res_done;
        rel_drop      = ~req[gnt_idx_reg];
        rel_wd        = (hold_cnt_reg == CW'(MAX_HOLD - 1));
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    state_next          = HOLD;
                    gnt_next            = '0;
                    gnt_next[win_idx]   = 1'b1;
                    gnt_idx_next        = win_idx;
                    last_idx_next       = win_idx;
                    hold_cnt_next       = '0;
                end
            end
            HOLD: begin
                if (rel_done || rel_drop || rel_wd) begin
                    state_next    = IDLE;
                    gnt_next      = '0;
                    hold_cnt_next = '0;
                    // Watchdog is only reported when it is the sole release cause.
                    timeout_next  = rel_wd && !rel_done && !rel_drop;
                end else if (!rel_wd) begin
                    hold_cnt_next = hold_cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            gnt_idx_reg  <= '0;
            last_idx_reg <= IW'(N_REQ - 1);
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            gnt_idx_reg  <= gnt_idx_next;
            last_idx_reg <= last_idx_next;
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_idx = gnt_idx_reg;
    assign gnt_vld = |gnt_reg;
    assign timeout = timeout_reg;

endmodule
